// File: rtl/cnt5_pkg.sv
// cnt5_pkg: shared constants, state encoding and mod-5 step helper for the 5-state one-hot counter bus
package cnt5_pkg;
  localparam int N_STATES = 5;
  localparam logic [4:0] ZERO  = 5'b00001;
  localparam logic [4:0] ONE   = 5'b00010;
  localparam logic [4:0] TWO   = 5'b00100;
  localparam logic [4:0] THREE = 5'b01000;
  localparam logic [4:0] FOUR  = 5'b10000;
  localparam logic [2:0] LAST  = 3'(N_STATES - 1);
  typedef enum logic [2:0] {SYNC = 3'b001, TRACK = 3'b010, FAULT = 3'b100} state_t;
  function automatic logic [2:0] step5(input logic [2:0] i, input logic up);
    return up ? ((i == LAST) ? 3'd0 : i + 3'd1) : ((i == 3'd0) ? LAST : i - 3'd1);
  endfunction
endpackage

// File: rtl/cnt5_o_monitor_if.sv
// cnt5_o_monitor_if: observed count bus plus the monitor's status outputs
interface cnt5_o_monitor_if #(parameter int WRAP_W = 8);
  logic [4:0]        cnt_oh;
  logic              clr_err;
  logic [2:0]        idx;
  logic              valid;
  logic              dir_up;
  logic              dir_dn;
  logic              err_onehot;
  logic              err_jump;
  logic [WRAP_W-1:0] wrap_cnt;
  modport master (output cnt_oh, clr_err,
                  input  idx, valid, dir_up, dir_dn, err_onehot, err_jump, wrap_cnt);
  modport slave  (input  cnt_oh, clr_err,
                  output idx, valid, dir_up, dir_dn, err_onehot, err_jump, wrap_cnt);
endinterface

// File: rtl/onehot5_dec.sv
// onehot5_dec: decodes a 5-bit one-hot code into a legality flag and binary index
module onehot5_dec (
  input  logic [4:0] oh,
  output logic       legal,
  output logic [2:0] idx
);
  assign legal = $onehot(oh);
  assign idx = oh[1] ? 3'd1 : oh[2] ? 3'd2 : oh[3] ? 3'd3 : oh[4] ? 3'd4 : 3'd0;
endmodule

// File: rtl/cnt5_o_monitor.sv
// cnt5_o_monitor: locks onto the one-hot count, infers direction, counts wraps, flags bad codes/steps
module cnt5_o_monitor
  import cnt5_pkg::*;
#(
  parameter int WRAP_W  = 8,
  parameter int HOLD_OK = 1
) (
  input logic clk,
  input logic rst,
  cnt5_o_monitor_if.slave bus
);
  logic [4:0]        s_oh;
  logic              legal;
  logic [2:0]        d_idx;
  state_t            state, state_n;
  logic [2:0]        idx_n;
  logic              up_n, dn_n, eo_set, ej_set;
  logic [WRAP_W-1:0] wrap_n;
  onehot5_dec u_dec (.oh(s_oh), .legal(legal), .idx(d_idx));
  always_comb begin
    state_n = state;
    idx_n   = bus.idx;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    eo_set  = 1'b0;
    ej_set  = 1'b0;
    wrap_n  = bus.wrap_cnt;
    unique case (state)
      SYNC: begin
        eo_set = ~legal;
        if (legal) begin
          idx_n   = d_idx;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (!legal) begin
          eo_set  = 1'b1;
          state_n = FAULT;
        end else begin
          idx_n = d_idx;
          if (d_idx == step5(bus.idx, 1'b1)) begin
            up_n   = 1'b1;
            wrap_n = (bus.idx == LAST) ? bus.wrap_cnt + WRAP_W'(1) : bus.wrap_cnt;
          end else if (d_idx == step5(bus.idx, 1'b0)) begin
            dn_n   = 1'b1;
            wrap_n = (bus.idx == 3'd0) ? bus.wrap_cnt - WRAP_W'(1) : bus.wrap_cnt;
          end else if (!(d_idx == bus.idx && HOLD_OK != 0)) begin
            ej_set  = 1'b1;
            state_n = FAULT;
          end
        end
      end
      FAULT:   state_n = bus.clr_err ? SYNC : FAULT;
      default: state_n = SYNC;
    endcase
  end
  // a freshly detected error outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_oh           <= '0;
      state          <= SYNC;
      bus.idx        <= '0;
      bus.valid      <= 1'b0;
      bus.dir_up     <= 1'b0;
      bus.dir_dn     <= 1'b0;
      bus.err_onehot <= 1'b0;
      bus.err_jump   <= 1'b0;
      bus.wrap_cnt   <= '0;
    end else begin
      s_oh           <= bus.cnt_oh;
      state          <= state_n;
      bus.idx        <= idx_n;
      bus.valid      <= state_n == TRACK;
      bus.dir_up     <= up_n;
      bus.dir_dn     <= dn_n;
      bus.err_onehot <= eo_set | (bus.err_onehot & ~bus.clr_err);
      bus.err_jump   <= ej_set | (bus.err_jump & ~bus.clr_err);
      bus.wrap_cnt   <= wrap_n;
    end
  end
endmodule

// File: tb/tb_cnt5_o_monitor.sv
// tb_cnt5_o_monitor: directed test-plan scenarios plus random walks, checked against a mod-5 reference model
module tb_cnt5_o_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  cnt5_o_monitor_if #(.WRAP_W(8)) b1 ();
  cnt5_o_monitor_if #(.WRAP_W(8)) b0 ();
  cnt5_o_monitor #(.WRAP_W(8), .HOLD_OK(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  cnt5_o_monitor #(.WRAP_W(8), .HOLD_OK(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  typedef struct {
    int         mode;
    int         idx;
    bit         up, dn, eo, ej;
    logic [7:0] wrap;
    logic [4:0] s;
  } model_t;
  model_t m[2];
  logic [15:0] o1, o0;
  assign o1 = {b1.idx, b1.valid, b1.dir_up, b1.dir_dn, b1.err_onehot, b1.err_jump, b1.wrap_cnt};
  assign o0 = {b0.idx, b0.valid, b0.dir_up, b0.dir_dn, b0.err_onehot, b0.err_jump, b0.wrap_cnt};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].mode = 0; m[k].idx = 0; m[k].up = 0; m[k].dn = 0;
      m[k].eo = 0; m[k].ej = 0; m[k].wrap = 8'd0; m[k].s = 5'd0;
    end
  endtask
  // mode: 0 searching, 1 locked, 2 faulted
  task automatic model_step(input int k, input bit hold_ok, input logic [4:0] oh, input bit clr);
    bit legal, neo, nej;
    int d, delta;
    legal = $countones(m[k].s) == 1;
    d = 0;
    for (int i = 0; i < 5; i++) if (m[k].s[i]) d = i;
    neo = 0; nej = 0;
    m[k].up = 0; m[k].dn = 0;
    if (m[k].mode == 0) begin
      if (legal) begin m[k].idx = d; m[k].mode = 1; end
      else neo = 1;
    end else if (m[k].mode == 1) begin
      if (!legal) begin neo = 1; m[k].mode = 2; end
      else begin
        delta = (d + 5 - m[k].idx) % 5;
        if (delta == 1) begin
          m[k].up = 1;
          if (m[k].idx == 4) m[k].wrap = m[k].wrap + 8'd1;
        end else if (delta == 4) begin
          m[k].dn = 1;
          if (m[k].idx == 0) m[k].wrap = m[k].wrap - 8'd1;
        end else if (!(delta == 0 && hold_ok)) begin
          nej = 1; m[k].mode = 2;
        end
        m[k].idx = d;
      end
    end else if (clr) m[k].mode = 0;
    m[k].eo = neo | (m[k].eo & ~clr);
    m[k].ej = nej | (m[k].ej & ~clr);
    m[k].s = oh;
  endtask
  function automatic logic [15:0] mpack(input int k);
    return {3'(m[k].idx), m[k].mode == 1, m[k].up, m[k].dn, m[k].eo, m[k].ej, m[k].wrap};
  endfunction
  task automatic cyc(input logic [4:0] oh, input bit clr);
    @(negedge clk);
    b1.cnt_oh = oh; b0.cnt_oh = oh; b1.clr_err = clr; b0.clr_err = clr;
    @(posedge clk);
    model_step(0, 1'b1, oh, clr);
    model_step(1, 1'b0, oh, clr);
    #1;
    chk("hold_ok1", o1, mpack(0));
    chk("hold_ok0", o0, mpack(1));
  endtask
  task automatic async_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst1", o1, 16'd0);
    chk("arst0", o0, 16'd0);
    #1 rst = 1'b0;
  endtask
  function automatic logic [4:0] oh_of(input int i);
    return 5'(1 << i);
  endfunction
  initial begin
    int p, r, nxt;
    logic [4:0] v;
    b1.cnt_oh = 5'd0; b0.cnt_oh = 5'd0; b1.clr_err = 1'b0; b0.clr_err = 1'b0;
    async_rst();
    chk("rst_out", o1, 16'd0);
    // up sweep
    for (int i = 0; i < 6; i++) cyc(oh_of(i % 5), 1'b0);
    cyc(oh_of(0), 1'b0);
    chk("up_wrap", b1.wrap_cnt, 8'd1);
    chk("up_idx", b1.idx, 3'd0);
    chk("up_dir", b1.dir_up, 1'b1);
    // down sweep
    async_rst();
    cyc(oh_of(0), 1'b0); cyc(oh_of(4), 1'b0); cyc(oh_of(3), 1'b0); cyc(oh_of(3), 1'b0);
    chk("dn_wrap", b1.wrap_cnt, 8'hFF);
    chk("dn_dir", b1.dir_dn, 1'b1);
    chk("dn_idx", b1.idx, 3'd3);
    // illegal code then clear and relock
    async_rst();
    cyc(oh_of(0), 1'b0); cyc(oh_of(1), 1'b0); cyc(oh_of(2), 1'b0);
    cyc(5'b00110, 1'b0); cyc(5'b00110, 1'b0);
    chk("ill_eo", b1.err_onehot, 1'b1);
    chk("ill_valid", b1.valid, 1'b0);
    chk("ill_idx", b1.idx, 3'd2);
    cyc(oh_of(3), 1'b1);
    chk("clr_eo", b1.err_onehot, 1'b0);
    cyc(oh_of(3), 1'b0);
    chk("relock_valid", b1.valid, 1'b1);
    chk("relock_idx", b1.idx, 3'd3);
    // jump
    async_rst();
    cyc(oh_of(0), 1'b0); cyc(oh_of(3), 1'b0); cyc(oh_of(3), 1'b0);
    chk("jmp_ej", b1.err_jump, 1'b1);
    chk("jmp_dir", {b1.dir_up, b1.dir_dn, b1.valid}, 3'b000);
    // hold
    async_rst();
    for (int i = 0; i < 4; i++) cyc(oh_of(2), 1'b0);
    chk("hold_valid", b1.valid, 1'b1);
    chk("hold_dir", {b1.dir_up, b1.dir_dn}, 2'b00);
    chk("hold0_ej", b0.err_jump, 1'b1);
    // clear colliding with a jump evaluation
    async_rst();
    cyc(oh_of(0), 1'b0); cyc(oh_of(3), 1'b0); cyc(oh_of(3), 1'b1);
    chk("coll_ej", b1.err_jump, 1'b1);
    chk("coll_valid", b1.valid, 1'b0);
    // async reset mid-sweep
    cyc(oh_of(3), 1'b1); cyc(oh_of(4), 1'b0); cyc(oh_of(0), 1'b0);
    async_rst();
    // random walk
    p = 0;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 15));
      nxt = (r < 6) ? (p + 1) % 5 : (r < 10) ? (p + 4) % 5 : (r < 12) ? p : (p + 2 + int'($urandom_range(0, 1))) % 5;
      v = (r == 13) ? 5'($urandom) : oh_of(nxt);
      if (r != 13) p = nxt;
      if ($urandom_range(0, 149) == 0) async_rst();
      cyc(v, $urandom_range(0, 9) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnt5_o_monitor.md
# cnt5_o_monitor

Receive-side checker for the 5-state one-hot up/down counter bus. It samples the 5-bit one-hot count every clock and decodes it to a binary index. It infers the step direction, tracks signed wrap-arounds, and flags illegal encodings or illegal transitions. It sits downstream of the counter, on the same clock, and feeds status and debug logic.

## Interface
Parameters:
- WRAP_W, 8, width of the signed wrap counter.
- HOLD_OK, 1, 1 = an unchanged state is legal; 0 = an unchanged state is a jump error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**.
- cnt_oh  in  5  one-hot count under observation; legal codes are 00001, 00010, 00100, 01000, 10000 (index 0..4).
- clr_err  in  1  clears the sticky error flags and exits FAULT.
- idx  out  3  binary index of the last legal sample.
- valid  out  1  the monitor is locked (state TRACK).
- dir_up  out  1  the last step was +1 mod 5.
- dir_dn  out  1  the last step was -1 mod 5.
- err_onehot  out  1  sticky flag: a sample was not a legal one-hot code.
- err_jump  out  1  sticky flag: an illegal transition between legal codes was seen.
- wrap_cnt  out  WRAP_W  signed net wrap count, two's complement.

## Operation
- **Input stage:** cnt_oh is registered into s_oh on every clk edge. Decode of s_oh:
  - legal when exactly one bit is set;
  - d_idx is the position of the set bit.
- **States:** SYNC, TRACK, FAULT. Reset enters SYNC. Every output resets to 0, and s_oh resets to 0.
- **SYNC:**
  - legal sample: load idx = d_idx, set valid = 1, go to TRACK; dir_up = dir_dn = 0.
  - illegal sample: set err_onehot, stay in SYNC.
- **TRACK**, comparing d_idx against idx:
  - d_idx = (idx+1) mod 5: dir_up = 1, dir_dn = 0. A step 4→0 increments wrap_cnt.
  - d_idx = (idx+4) mod 5: dir_dn = 1, dir_up = 0. A step 0→4 decrements wrap_cnt.
  - d_idx = idx: both dir outputs 0. If HOLD_OK = 0, set err_jump and go to FAULT.
  - any other legal code: set err_jump, go to FAULT.
  - illegal sample: set err_onehot, go to FAULT.
  - idx updates to d_idx on every legal sample.
- **FAULT:** valid = 0, dir_up = dir_dn = 0; idx and wrap_cnt hold. clr_err = 1 returns to SYNC.
- **clr_err in any state:** clears err_onehot and err_jump. It does not reset wrap_cnt.
- **clr_err in the same cycle as a new error:** the error wins; the flag is set and the state is FAULT.
- **wrap_cnt width:** wraps modulo 2^WRAP_W, with no saturation.
- **Asynchronous rst mid-operation:** immediately returns all state to its reset values.

## Timing
- cnt_oh is captured at edge N into s_oh. idx, dir_*, valid, errors and wrap_cnt reflect it after edge N+1, giving 2 cycles of latency.
- clr_err is sampled at edge N. The flags read 0 and the state is SYNC after edge N.
- Locking: after the first legal capture at edge N, valid = 1 after edge N+1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package** cnt5_pkg:
  - one-hot constants ZERO..FOUR (00001..10000);
  - state encoding SYNC/TRACK/FAULT, one-hot, 3 bits, matching the counter's encoding style;
  - constant N_STATES = 5.
- **Sub-module** onehot5_dec: combinational, s_oh → {legal, d_idx}. It is reused by any other consumer of the bus.
- **Top** cnt5_o_monitor: input register, FSM, step comparator, wrap counter, sticky flags.

## Test plan
- **Up sweep:** rst, then drive 00001, 00010, 00100, 01000, 10000, 00001 on consecutive cycles.
  - valid = 1 from the 2nd output cycle;
  - dir_up = 1 on each step;
  - idx sequence 0, 1, 2, 3, 4, 0;
  - wrap_cnt = 1.
- **Down sweep:** drive 00001, 10000, 01000. Required: dir_dn = 1, idx 0, 4, 3, and wrap_cnt = 0xFF (-1).
- **Illegal code:** in TRACK at idx = 2, drive 00110.
  - err_onehot = 1 and valid = 0 two cycles later;
  - idx holds at 2.
  - Then pulse clr_err with legal 01000: flag clears, SYNC, relock to idx = 3.
- **Jump:** 00001 then 01000. Required: err_jump = 1, FAULT, dir_up = dir_dn = 0.
- **Hold:** with HOLD_OK = 1, 00100 held for 3 cycles keeps valid = 1 with both dir outputs 0. With HOLD_OK = 0, the second identical sample sets err_jump.
- **Collisions:**
  - clr_err in the same cycle as a jump capture: err_jump = 1, state FAULT.
  - async rst asserted mid-sweep: all outputs read 0 before the next clk edge.
